pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register with valid/ready handshake, optional two-entry skid buffer, synchronous flush and a saturating stall counter. It replaces the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) between any two core stages. Back-pressure is carried through the handshake rather than by gating the clock. Flush squashes in-flight beats by clearing their valid and control bits.

## Interface
- DATA_W, 128, payload width (PC, IR, operands, register indices); preserved on flush unless CLR_DATA=1
- CTRL_W, 8, control-bit width (RegWrite, MemWrite, MemtoReg, ...); always zeroed on flush
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
- CLR_DATA, 1, 1 = flush and reset also zero the data field
- STALL_CNT_W, 16, stall counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- flush  in  1  synchronous squash of every beat held in the stage
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat
- in_ctrl  in  CTRL_W  upstream control bits
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  head beat valid
- out_ready  in  1  downstream accepts the head beat
- out_ctrl  out  CTRL_W  head control bits
- out_data  out  DATA_W  head payload
- occupancy  out  2  beats held (0..2; never exceeds 1 when SKID=0)
- stall_cnt  out  STALL_CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

## Operation
- Input transfer (push): in_valid && in_ready. Output transfer (pop): out_valid && out_ready.
- Beats leave in arrival order.
- SKID=1: two registers, main and skid.
  - main drives the out_* ports.
  - Three states: EMPTY, ONE (main full), TWO (main and skid full).
  - EMPTY + push -> ONE; main <= in.
  - ONE + push only -> TWO; skid <= in.
  - ONE + pop only -> EMPTY.
  - ONE + push + pop -> ONE; main <= in.
  - TWO + pop -> ONE; main <= skid. A push cannot occur in TWO because in_ready=0.
  - No push or pop: hold state and contents.
- SKID=0: single register.
  - in_ready = !out_valid || out_ready (combinational).
  - A push loads the register.
  - A pop without a push clears out_valid.
- Flush (priority below reset, above everything else):
  - Next state EMPTY.
  - All valids cleared; out_ctrl and skid ctrl zeroed; data zeroed only if CLR_DATA=1.
  - Any beat presented by upstream in the flush cycle is discarded, even if in_ready=1.
- Squashed and empty entries always present out_ctrl = 0. Downstream never sees a stale write-enable.
- stall_cnt: +1 each cycle with out_valid && !out_ready; holds at 2^STALL_CNT_W-1. It is not cleared by flush.
- occupancy encodes EMPTY/ONE/TWO as 0/1/2.

## Timing
- Reset (rst=0, asynchronous):
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0.
  - in_ready=1 (both modes).
- Latency: a beat pushed in cycle N is visible on out_* in cycle N+1 when the stage was EMPTY (or ONE with a simultaneous pop).
- Throughput: 1 beat/cycle when out_ready is held high.
- SKID=1:
  - in_ready is a register output: 1 in EMPTY/ONE, 0 in TWO.
  - There is no combinational path from out_ready to in_ready.
- Flush:
  - Asserted in cycle N gives out_valid=0, out_ctrl=0 and in_ready=1 in N+1.
  - A pop in cycle N still completes downstream.
- Reset deasserting mid-stream: the first push is accepted on the first rising edge with rst=1.
- out_* are stable while out_valid && !out_ready.

## Test plan
- Reset: with rst=0, drive in_valid=1, in_ctrl=8'hFF. Required: out_valid=0, out_ctrl=0, occupancy=0, in_ready=1. After rst=1, the first edge loads the beat; out_ctrl=8'hFF next cycle.
- Streaming: out_ready=1, push beats with data 1..100 back-to-back. Required: out_data 1..100 in order, one per cycle after 1-cycle latency, stall_cnt=0.
- Back-pressure (SKID=1):
  - Push beats A, B, C with out_ready=0. Required: A and B accepted, occupancy=2, in_ready=0 while C is held upstream, stall_cnt increments each cycle.
  - Then raise out_ready. Required: output order A, B, C with no loss or duplication.
- Flush in TWO: in_ctrl=8'h05 on both held beats, assert flush together with a new push. Required: next cycle out_valid=0, out_ctrl=0, occupancy=0; pushed beat discarded; out_data=0 when CLR_DATA=1, previous value when CLR_DATA=0.
- SKID=0 with random out_ready: 1000 beats. Required: in_ready == (!out_valid || out_ready) every cycle; scoreboard matches in-order.
- Saturation: STALL_CNT_W=4, out_valid held with out_ready=0 for 20 cycles. Required: stall_cnt stops at 15.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a valid/ready handshake. An optional two-entry
// skid buffer gives a registered in_ready. A synchronous flush squashes every
// held beat, and a saturating counter records downstream stall cycles.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no beat held, out_valid=0, in_ready=1
// ST_ONE   | main holds the head beat
// ST_TWO   | main and skid both full, in_ready=0 (SKID=1 only)

module pipe_stage_reg #(
   parameter int DATA_W      = 128,
   parameter int CTRL_W      = 8,
   parameter int SKID        = 1,
   parameter int CLR_DATA    = 1,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [CTRL_W-1:0]      in_ctrl,
   input  logic [DATA_W-1:0]      in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CTRL_W-1:0]      out_ctrl,
   output logic [DATA_W-1:0]      out_data,
   output logic [1:0]             occupancy,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   localparam logic [STALL_CNT_W-1:0] STALL_ONE = 1;

   state_t                  state;
   logic [CTRL_W-1:0]       main_ctrl;
   logic [CTRL_W-1:0]       skid_ctrl;
   logic [DATA_W-1:0]       main_data;
   logic [DATA_W-1:0]       skid_data;
   logic                    in_ready_r;
   logic                    out_valid_r;
   logic [STALL_CNT_W-1:0]  stall_cnt_r;
   logic                    push;
   logic                    pop;

   // Skid mode breaks the out_ready -> in_ready path with a register;
   // single-register mode accepts whenever the head drains this cycle.
   assign in_ready  = (SKID != 0) ? in_ready_r : (!out_valid_r || out_ready);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid_r && out_ready;

   assign out_valid = out_valid_r;
   assign out_ctrl  = main_ctrl;
   assign out_data  = main_data;
   assign occupancy = 2'(state);
   assign stall_cnt = stall_cnt_r;

   // Occupancy FSM; ctrl of every vacated entry is zeroed so no stale enables leak out.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_EMPTY;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
         main_ctrl   <= '0;
         skid_ctrl   <= '0;
         main_data   <= '0;
         skid_data   <= '0;
      end else if (flush) begin
         state       <= ST_EMPTY;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
         main_ctrl   <= '0;
         skid_ctrl   <= '0;
         if (CLR_DATA != 0) begin
            main_data <= '0;
            skid_data <= '0;
         end
      end else begin
         case (state)
            ST_EMPTY: begin
               if (push) begin
                  state       <= ST_ONE;
                  out_valid_r <= 1'b1;
                  main_ctrl   <= in_ctrl;
                  main_data   <= in_data;
               end
            end
            ST_ONE: begin
               if (push && pop) begin
                  main_ctrl <= in_ctrl;
                  main_data <= in_data;
               end else if (push && (SKID != 0)) begin
                  state      <= ST_TWO;
                  in_ready_r <= 1'b0;
                  skid_ctrl  <= in_ctrl;
                  skid_data  <= in_data;
               end else if (pop) begin
                  state       <= ST_EMPTY;
                  out_valid_r <= 1'b0;
                  main_ctrl   <= '0;
               end
            end
            ST_TWO: begin
               if (pop) begin
                  state      <= ST_ONE;
                  in_ready_r <= 1'b1;
                  main_ctrl  <= skid_ctrl;
                  main_data  <= skid_data;
                  skid_ctrl  <= '0;
               end
            end
            default: begin
               state       <= ST_EMPTY;
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               main_ctrl   <= '0;
               skid_ctrl   <= '0;
            end
         endcase
      end
   end

   // Saturating stall counter; deliberately survives flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_r <= '0;
      end else if (out_valid_r && !out_ready && (stall_cnt_r != '1)) begin
         stall_cnt_r <= stall_cnt_r + STALL_ONE;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three configurations driven by a common upstream
// and downstream, each checked every cycle against a small FIFO model.
// dut0: SKID=1 CLR_DATA=1 STALL_CNT_W=4
// dut1: SKID=0 CLR_DATA=0 STALL_CNT_W=16
// dut2: SKID=1 CLR_DATA=0 STALL_CNT_W=16

module tb_pipe_stage_reg;

   localparam int N  = 3;
   localparam int DW = 32;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          flush;
   logic          out_ready;
   logic          in_valid;
   logic [CW-1:0] in_ctrl;
   logic [DW-1:0] in_data   [N];
   logic          in_ready  [N];
   logic          out_valid [N];
   logic [CW-1:0] out_ctrl  [N];
   logic [DW-1:0] out_data  [N];
   logic [1:0]    occ       [N];
   logic [3:0]    stall_a;
   logic [15:0]   stall_b;
   logic [15:0]   stall_c;
   logic [15:0]   stall_v   [N];

   // model state: up to two held beats per dut, plus the lingering data field
   logic [CW-1:0] mc   [N][2];
   logic [DW-1:0] md   [N][2];
   int            cnt  [N];
   logic [DW-1:0] hold [N];
   int            stall_m [N];
   bit            push_flag [N];
   logic [DW-1:0] seq [N];
   logic [DW-1:0] first_seq [N];
   bit            vm, rm, pu, po;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   always_comb begin
      stall_v[0] = {12'b0, stall_a};
      stall_v[1] = stall_b;
      stall_v[2] = stall_c;
   end

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CLR_DATA(1), .STALL_CNT_W(4)) u_dut0 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready[0]), .in_ctrl(in_ctrl), .in_data(in_data[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready), .out_ctrl(out_ctrl[0]), .out_data(out_data[0]),
      .occupancy(occ[0]), .stall_cnt(stall_a));

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CLR_DATA(0), .STALL_CNT_W(16)) u_dut1 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready[1]), .in_ctrl(in_ctrl), .in_data(in_data[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready), .out_ctrl(out_ctrl[1]), .out_data(out_data[1]),
      .occupancy(occ[1]), .stall_cnt(stall_b));

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CLR_DATA(0), .STALL_CNT_W(16)) u_dut2 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready[2]), .in_ctrl(in_ctrl), .in_data(in_data[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready), .out_ctrl(out_ctrl[2]), .out_data(out_data[2]),
      .occupancy(occ[2]), .stall_cnt(stall_c));

   function automatic bit skid_of(int d);
      return d != 1;
   endfunction

   function automatic bit clr_of(int d);
      return d == 0;
   endfunction

   function automatic int smax_of(int d);
      return (d == 0) ? 15 : 65535;
   endfunction

   task automatic chk(string name, int d, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d got %0h expected %0h at %0t", name, d, act, exp, $time);
      end
   endtask

   // Compare every dut against the model, then advance the model by one edge.
   always @(negedge clk) begin
      for (int d = 0; d < N; d++) begin
         if (!rst) begin
            chk("rst_valid", d, 64'(out_valid[d]), 64'd0);
            chk("rst_ctrl",  d, 64'(out_ctrl[d]),  64'd0);
            chk("rst_data",  d, 64'(out_data[d]),  64'd0);
            chk("rst_occ",   d, 64'(occ[d]),       64'd0);
            chk("rst_ready", d, 64'(in_ready[d]),  64'd1);
            chk("rst_stall", d, 64'(stall_v[d]),   64'd0);
            cnt[d]       = 0;
            hold[d]      = '0;
            stall_m[d]   = 0;
            push_flag[d] = 1'b0;
         end else begin
            vm = cnt[d] > 0;
            rm = skid_of(d) ? (cnt[d] < 2) : (cnt[d] == 0 || out_ready);
            chk("valid", d, 64'(out_valid[d]), 64'(vm));
            chk("ctrl",  d, 64'(out_ctrl[d]),  vm ? 64'(mc[d][0]) : 64'd0);
            chk("data",  d, 64'(out_data[d]),  vm ? 64'(md[d][0]) : 64'(hold[d]));
            chk("occ",   d, 64'(occ[d]),       64'(cnt[d]));
            chk("ready", d, 64'(in_ready[d]),  64'(rm));
            chk("stall", d, 64'(stall_v[d]),   64'(stall_m[d]));
            po = vm && out_ready;
            pu = in_valid && rm && !flush;
            push_flag[d] = pu;
            if (vm && !out_ready && stall_m[d] < smax_of(d)) stall_m[d]++;
            if (flush) begin
               cnt[d] = 0;
               if (clr_of(d)) hold[d] = '0;
            end else begin
               if (po) begin
                  mc[d][0] = mc[d][1];
                  md[d][0] = md[d][1];
                  cnt[d]--;
               end
               if (pu) begin
                  mc[d][cnt[d]] = in_ctrl;
                  md[d][cnt[d]] = in_data[d];
                  cnt[d]++;
               end
            end
            if (cnt[d] > 0) hold[d] = md[d][0];
         end
      end
   end

   // Advance one cycle; each dut's upstream presents its next sequence number once accepted.
   task automatic tick();
      @(posedge clk);
      #1;
      for (int d = 0; d < N; d++) begin
         if (push_flag[d]) seq[d] = seq[d] + 1;
         in_data[d] = seq[d];
      end
   endtask

   initial begin
      flush     = 1'b0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_ctrl   = 8'hFF;
      for (int d = 0; d < N; d++) begin
         seq[d]       = '0;
         first_seq[d] = '0;
         in_data[d]   = '0;
      end

      // reset held with a beat presented, then released
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      tick();
      in_ctrl = 8'($urandom);
      @(negedge clk);
      for (int d = 0; d < N; d++) begin
         chk("first_ctrl",  d, 64'(out_ctrl[d]),  64'hFF);
         chk("first_valid", d, 64'(out_valid[d]), 64'd1);
      end

      // streaming beats 1..100 with out_ready high
      for (int k = 1; k <= 100; k++) begin
         tick();
         in_valid = (k < 100);
         in_ctrl  = 8'($urandom);
         @(negedge clk);
         for (int d = 0; d < N; d++) chk("stream_data", d, 64'(out_data[d]), 64'(k));
      end
      for (int d = 0; d < N; d++) chk("stream_stall", d, 64'(stall_v[d]), 64'd0);
      repeat (2) tick();

      // back-pressure: beats held upstream while out_ready is low
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      @(negedge clk);
      for (int k = 1; k <= 5; k++) begin
         tick();
         in_ctrl = 8'($urandom);
         @(negedge clk);
         for (int d = 0; d < N; d++) chk("bp_stall", d, 64'(stall_v[d]), 64'(k - 1));
      end
      chk("bp_occ",   0, 64'(occ[0]),      64'd2);
      chk("bp_ready", 0, 64'(in_ready[0]), 64'd0);
      chk("bp_occ",   1, 64'(occ[1]),      64'd1);
      chk("bp_ready", 1, 64'(in_ready[1]), 64'd0);
      chk("bp_occ",   2, 64'(occ[2]),      64'd2);
      tick();
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();

      // flush while two beats are held, with a new beat presented
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = 8'h05;
      for (int d = 0; d < N; d++) first_seq[d] = seq[d];
      repeat (2) tick();
      flush   = 1'b1;
      in_ctrl = 8'h77;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      for (int d = 0; d < N; d++) begin
         chk("flush_valid", d, 64'(out_valid[d]), 64'd0);
         chk("flush_ctrl",  d, 64'(out_ctrl[d]),  64'd0);
         chk("flush_occ",   d, 64'(occ[d]),       64'd0);
         chk("flush_ready", d, 64'(in_ready[d]),  64'd1);
         chk("flush_stall", d, 64'(stall_v[d]),   64'd7);
      end
      chk("flush_data", 0, 64'(out_data[0]), 64'd0);
      chk("flush_data", 1, 64'(out_data[1]), 64'(first_seq[1]));
      chk("flush_data", 2, 64'(out_data[2]), 64'(first_seq[2]));

      // stall counter saturation on the 4-bit instance
      tick();
      in_valid = 1'b1;
      repeat (20) tick();
      @(negedge clk);
      chk("stall_sat", 0, 64'(stall_v[0]), 64'd15);
      tick();
      out_ready = 1'b1;
      in_valid  = 1'b0;
      repeat (3) tick();

      // random traffic with occasional flush and one reset mid-stream
      for (int i = 0; i < 3000; i++) begin
         tick();
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(2) != 0);
         in_ctrl   = 8'($urandom);
         flush     = ($urandom_range(39) == 0);
         if (i == 1500) rst = 1'b0;
         if (i == 1503) rst = 1'b1;
      end
      tick();
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
